// File: rtl/traffic_light_timer.sv
// Traffic-light sequencer: GREEN -> YELLOW -> RED -> GREEN with a two-digit
// BCD countdown, pause, manual phase skip and flashing-yellow night mode.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_GREEN  | green lamp on, counting down GREEN_TIME seconds
// ST_YELLOW | yellow lamp on, counting down YELLOW_TIME seconds
// ST_RED    | red lamp on, counting down RED_TIME seconds
// ST_NIGHT  | digits 00, yellow lamp toggles once per second
module traffic_light_timer #(
    parameter int CLK_DIV     = 50000000,
    parameter int GREEN_TIME  = 25,
    parameter int YELLOW_TIME = 3,
    parameter int RED_TIME    = 30
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       EN,
    input  logic       SKIP,
    input  logic       NIGHT,
    output logic [3:0] DIGIT0,
    output logic [3:0] DIGIT1,
    output logic       GREEN,
    output logic       YELLOW,
    output logic       RED,
    output logic       TICK
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_RED    = 2'd2,
        ST_NIGHT  = 2'd3
    } state_t;

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);

    localparam logic [3:0] G_TENS  = 4'(GREEN_TIME / 10);
    localparam logic [3:0] G_UNITS = 4'(GREEN_TIME % 10);
    localparam logic [3:0] Y_TENS  = 4'(YELLOW_TIME / 10);
    localparam logic [3:0] Y_UNITS = 4'(YELLOW_TIME % 10);
    localparam logic [3:0] R_TENS  = 4'(RED_TIME / 10);
    localparam logic [3:0] R_UNITS = 4'(RED_TIME % 10);

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          tick;

    state_t        nxt_state;
    logic [3:0]    nxt_tens;
    logic [3:0]    nxt_units;
    logic          last_second;

    // One-second strobe, decoded straight from the prescaler so it lines up
    // with the edge that acts on it.
    assign tick = (prescaler == PRESC_LAST) && EN && !CLR;
    assign TICK = tick;

    // The display reads 01 on the final second of a phase; 00 is treated the
    // same so a corrupted count can never stall the sequence.
    assign last_second = (DIGIT1 == 4'd0) && (DIGIT0 <= 4'd1);

    // Following phase and its BCD load value; the night encoding falls back
    // to a green reload.
    always_comb begin
        nxt_state = ST_GREEN;
        nxt_tens  = G_TENS;
        nxt_units = G_UNITS;
        case (state)
            ST_GREEN: begin
                nxt_state = ST_YELLOW;
                nxt_tens  = Y_TENS;
                nxt_units = Y_UNITS;
            end
            ST_YELLOW: begin
                nxt_state = ST_RED;
                nxt_tens  = R_TENS;
                nxt_units = R_UNITS;
            end
            default: begin
                nxt_state = ST_GREEN;
                nxt_tens  = G_TENS;
                nxt_units = G_UNITS;
            end
        endcase
    end

    // Sequencer: reset, then night entry/exit, then skip, then the countdown.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= ST_GREEN;
            prescaler <= '0;
            DIGIT1    <= G_TENS;
            DIGIT0    <= G_UNITS;
            GREEN     <= 1'b1;
            YELLOW    <= 1'b0;
            RED       <= 1'b0;
        end else if (NIGHT) begin
            if (state != ST_NIGHT) begin
                state     <= ST_NIGHT;
                prescaler <= '0;
                DIGIT1    <= 4'd0;
                DIGIT0    <= 4'd0;
                GREEN     <= 1'b0;
                YELLOW    <= 1'b1;
                RED       <= 1'b0;
            end else begin
                if (EN) begin
                    prescaler <= (prescaler == PRESC_LAST) ? '0 : prescaler + 1'b1;
                end
                if (tick) begin
                    YELLOW <= ~YELLOW;
                end
            end
        end else if (state == ST_NIGHT) begin
            // Leaving night mode always resumes on a full red phase.
            state     <= ST_RED;
            prescaler <= '0;
            DIGIT1    <= R_TENS;
            DIGIT0    <= R_UNITS;
            GREEN     <= 1'b0;
            YELLOW    <= 1'b0;
            RED       <= 1'b1;
        end else if (SKIP || (tick && last_second)) begin
            state     <= nxt_state;
            DIGIT1    <= nxt_tens;
            DIGIT0    <= nxt_units;
            GREEN     <= (nxt_state == ST_GREEN);
            YELLOW    <= (nxt_state == ST_YELLOW);
            RED       <= (nxt_state == ST_RED);
            if (SKIP) begin
                prescaler <= '0;
            end else begin
                prescaler <= (prescaler == PRESC_LAST) ? '0 : prescaler + 1'b1;
            end
        end else begin
            if (EN) begin
                prescaler <= (prescaler == PRESC_LAST) ? '0 : prescaler + 1'b1;
            end
            if (tick) begin
                if (DIGIT0 == 4'd0) begin
                    DIGIT0 <= 4'd9;
                    DIGIT1 <= DIGIT1 - 4'd1;
                end else begin
                    DIGIT0 <= DIGIT0 - 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/traffic_light_timer.md
Name: traffic_light_timer

Overview:
Parametrised single-direction traffic-light sequencer with a two-digit BCD countdown for 7-segment display. Three phases, GREEN -> YELLOW -> RED -> GREEN, each with its own duration. Adds pause, manual phase skip and a flashing-yellow night mode. Sits between the board clock and the per-digit BCD-to-7-segment decoders and status LEDs.

Parameters:
CLK_DIV, 50000000, CLK cycles per one-second tick (>=2)
GREEN_TIME, 25, green phase duration in seconds (1..99)
YELLOW_TIME, 3, yellow phase duration in seconds (1..99)
RED_TIME, 30, red phase duration in seconds (1..99)

Ports:
CLK  in  1  system clock, all logic on rising edge
CLR  in  1  synchronous active-high reset
EN  in  1  run enable; 0 = pause (prescaler and countdown hold)
SKIP  in  1  one-cycle request to end current phase immediately
NIGHT  in  1  level; 1 = night mode (flashing yellow)
DIGIT0  out  4  BCD units of remaining seconds
DIGIT1  out  4  BCD tens of remaining seconds
GREEN  out  1  green lamp
YELLOW  out  1  yellow lamp
RED  out  1  red lamp
TICK  out  1  one-cycle pulse per elapsed second

Behaviour:
- Priority per cycle: CLR > NIGHT > SKIP > tick.
- Reset (CLR=1 at edge): prescaler=0, state=GREEN, {DIGIT1,DIGIT0}=BCD(GREEN_TIME), GREEN=1, YELLOW=0, RED=0. TICK=0 while CLR=1. CLR mid-phase or mid-night discards all state.
- Prescaler: counts 0..CLK_DIV-1 when EN=1, wraps to 0. Holds when EN=0.
- tick = (prescaler==CLK_DIV-1) && EN && !CLR. TICK = tick, decoded from registers, same cycle.
- All other outputs registered. Lamps one-hot in GREEN/YELLOW/RED states.
- Countdown on tick, normal states:
  - Display value v > 1: BCD decrement. Units 0 -> 9 with tens-1. Otherwise units-1.
  - v == 1: advance to next phase, load that phase's time.
  - Each phase displays T, T-1, ..., 1 and lasts exactly T ticks.
  - Digits are never outside 0..9.
- SKIP=1 (normal state, NIGHT=0) at an edge: next cycle advances to next phase, loads its time, prescaler=0. SKIP coincident with tick: single advance only, no extra decrement. SKIP while EN=0 still acts. SKIP held high advances once per cycle.
- Night mode:
  - NIGHT=1 at an edge from any normal state: next cycle state=NIGHT, GREEN=RED=0, YELLOW=1, digits=00, prescaler=0.
  - In NIGHT, YELLOW toggles on each tick. EN still pauses. SKIP ignored.
  - NIGHT falling (NIGHT=0 at an edge while in NIGHT): next cycle state=RED, digits=BCD(RED_TIME), RED=1, others 0, prescaler=0.
- BCD load of parameter P: tens=P/10, units=P%10, computed at elaboration.
- States: GREEN, YELLOW, RED, NIGHT; 2-bit encoding; no unreachable-state lockup (decode unused values to GREEN reload).

Test Plan:
- CLK_DIV=4, G=3, Y=2, R=12; CLR pulse then EN=1 -> GREEN=1, digits 03,02,01 each lasting 4 cycles; 12th cycle after reset -> YELLOW=1, digits 02; 20 cycles after reset -> RED=1, digits 12.
- Same config, run into RED -> digits 12,11,10,09 (borrow into tens), ..., 01 -> GREEN with 03; TICK high exactly 1 cycle in every 4.
- EN=0 for 10 cycles mid-GREEN at digits 02 -> digits, lamps and prescaler frozen, TICK=0; EN=1 -> countdown resumes with the remaining prescaler count.
- SKIP pulse in GREEN at digits 03 -> next cycle YELLOW=1, digits 02, prescaler 0; SKIP on the same cycle as a tick -> exactly one phase advance.
- NIGHT=1 during YELLOW -> next cycle YELLOW=1, G=R=0, digits 00; YELLOW toggles every 4 cycles; SKIP ignored; NIGHT=0 -> RED=1, digits 12.
- CLR asserted mid-RED together with NIGHT=1 and SKIP=1 -> reset state wins: GREEN=1, digits 03, TICK=0.
